// File: rtl/bvh_prim_port_arbiter_pkg.sv
// Shared types and widths for the BVH / primitive port arbiter.
//   arb_state_e  : arbiter FSM states (ARB_Idle, ARB_Own, ARB_Drain)
//   return_tag_t : {valid, owner} carried down the read-return pipeline
//   BVH_NODE_INDEX_WIDTH / BVH_PRIMITIVE_INDEX_WIDTH : default index widths
package bvh_prim_port_arbiter_pkg;
    localparam int BVH_NODE_INDEX_WIDTH      = 8;
    localparam int BVH_PRIMITIVE_INDEX_WIDTH = 8;
    // Owner field is wide enough for the largest supported requester count (8).
    localparam int OWNER_W = 3;

    typedef enum logic [1:0] {
        ARB_Idle,
        ARB_Own,
        ARB_Drain
    } arb_state_e;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } return_tag_t;
endpackage

// File: rtl/bvh_prim_port_arbiter_if.sv
// Bundle between the traversal units and the shared BVH / primitive memory port.
// slave  : arbiter side (takes per-unit requests, drives grants and the muxed bus)
// master : traversal-unit / memory side
// Per-unit inputs are packed [NUM_REQ-1:0][W-1:0], unit i in slice i.
// release_pulse is the per-unit release (the plain name is a language keyword).
interface bvh_prim_port_arbiter_if
    import bvh_prim_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NODE_W  = BVH_NODE_INDEX_WIDTH,
    parameter int PRIM_W  = BVH_PRIMITIVE_INDEX_WIDTH
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             release_pulse;
    logic [NUM_REQ-1:0]             rd_en;
    logic [NUM_REQ-1:0][NODE_W-1:0] node_index_in;
    logic [NUM_REQ-1:0][PRIM_W-1:0] aabb_start_in;
    logic [NUM_REQ-1:0][PRIM_W-1:0] aabb_end_in;
    logic [NUM_REQ-1:0][PRIM_W-1:0] sphere_start_in;
    logic [NUM_REQ-1:0][PRIM_W-1:0] sphere_end_in;

    logic [NUM_REQ-1:0]             gnt;
    logic [NUM_REQ-1:0]             yield;
    logic [NODE_W-1:0]              node_index;
    logic [PRIM_W-1:0]              aabb_query_start;
    logic [PRIM_W-1:0]              aabb_query_end;
    logic [PRIM_W-1:0]              sphere_query_start;
    logic [PRIM_W-1:0]              sphere_query_end;
    logic                           mem_rd;
    logic [NUM_REQ-1:0]             rdata_valid;

    modport slave (
        input  req, release_pulse, rd_en, node_index_in,
               aabb_start_in, aabb_end_in, sphere_start_in, sphere_end_in,
        output gnt, yield, node_index, aabb_query_start, aabb_query_end,
               sphere_query_start, sphere_query_end, mem_rd, rdata_valid
    );

    modport master (
        output req, release_pulse, rd_en, node_index_in,
               aabb_start_in, aabb_end_in, sphere_start_in, sphere_end_in,
        input  gnt, yield, node_index, aabb_query_start, aabb_query_end,
               sphere_query_start, sphere_query_end, mem_rd, rdata_valid
    );
endinterface

// File: rtl/bvh_prim_port_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
//   req   : N-bit request vector
//   ptr   : index with highest priority; priority falls upward with wrap
//   idx   : chosen index (0 when nothing requested)
//   found : any request present
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);
    int          j;
    logic [IW-1:0] jj;

    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            jj = IW'(j);
            if (req[jj]) begin
                idx   = jj;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bvh_prim_port_arbiter.sv
// bvh_prim_port_arbiter: shares the BVH node-fetch port and the AABB/sphere
// query ports between NUM_REQ traversal units. One owner at a time,
// round-robin, grant held for a whole traversal (released by release_pulse).
// Reads are tagged with the owner and returned as a one-hot rdata_valid
// exactly MEM_LAT cycles after mem_rd.
// Ports:
//   clk, reset (asynchronous, active-high)
//   bus : bvh_prim_port_arbiter_if.slave (its NUM_REQ/NODE_W/PRIM_W must match)
// Optional: define BVH_ARB_PRIORITY_EN to give unit 0 absolute priority at the
// idle decision; round-robin still applies among the other units.
module bvh_prim_port_arbiter
    import bvh_prim_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NODE_W  = BVH_NODE_INDEX_WIDTH,
    parameter int PRIM_W  = BVH_PRIMITIVE_INDEX_WIDTH,
    parameter int MEM_LAT = 2,
    parameter int QUANTUM = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    bvh_prim_port_arbiter_if.slave  bus
);
    localparam int OW  = $clog2(NUM_REQ);
    localparam int IFW = $clog2(MEM_LAT + 1);
    localparam int QW  = $clog2(QUANTUM + 1);

    arb_state_e         state, state_nxt;
    logic [OW-1:0]      owner, rr_ptr, ptr_after;
    logic [OW-1:0]      rr_idx, pick_idx;
    logic               rr_found, pick_found;
    logic [NUM_REQ-1:0] rr_req, owner_oh;
    logic [IFW-1:0]     inflight, inflight_nxt;
    logic [QW-1:0]      quantum_cnt;
    logic               yield_hold, quantum_hit, others_waiting;
    logic               own, rel, issue, tail_vld;
    return_tag_t        tag_in;
    return_tag_t        tag_pipe [MEM_LAT:1];

    rr_pick #(.N(NUM_REQ), .IW(OW)) u_rr_pick (
        .req   (rr_req),
        .ptr   (rr_ptr),
        .idx   (rr_idx),
        .found (rr_found)
    );

`ifdef BVH_ARB_PRIORITY_EN
    assign rr_req     = bus.req & ~NUM_REQ'(1);
    assign pick_idx   = bus.req[0] ? '0 : rr_idx;
    assign pick_found = bus.req[0] | rr_found;
`else
    assign rr_req     = bus.req;
    assign pick_idx   = rr_idx;
    assign pick_found = rr_found;
`endif

    assign own            = (state == ARB_Own);
    assign owner_oh       = NUM_REQ'(1) << owner;
    assign issue          = own & bus.rd_en[owner];
    assign rel            = own & bus.release_pulse[owner];
    assign tail_vld       = tag_pipe[MEM_LAT].valid;
    assign others_waiting = |(bus.req & ~owner_oh);
    assign quantum_hit    = (quantum_cnt == QW'(QUANTUM)) & others_waiting;
    assign ptr_after      = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);

    assign tag_in.valid = issue;
    assign tag_in.owner = OWNER_W'(owner);

    always_comb begin
        inflight_nxt = inflight;
        unique case ({issue, tail_vld})
            2'b10:   inflight_nxt = inflight + IFW'(1);
            2'b01:   inflight_nxt = inflight - IFW'(1);
            default: inflight_nxt = inflight;
        endcase
    end

    // Release counts the read issued in the same cycle, so drain covers it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_Idle:  if (pick_found) state_nxt = ARB_Own;
            ARB_Own:   if (rel) state_nxt = (inflight_nxt != '0) ? ARB_Drain : ARB_Idle;
            ARB_Drain: if (inflight == '0) state_nxt = ARB_Idle;
            default:   state_nxt = ARB_Idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ARB_Idle;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner       <= '0;
            rr_ptr      <= '0;
            inflight    <= '0;
            quantum_cnt <= '0;
            yield_hold  <= 1'b0;
        end else begin
            inflight <= inflight_nxt;
            if (state == ARB_Idle && pick_found) begin
                owner       <= pick_idx;
                // The first owned cycle already counts toward the quantum.
                quantum_cnt <= QW'(1);
                yield_hold  <= 1'b0;
            end else if (own) begin
                if (rel) begin
                    rr_ptr      <= ptr_after;
                    quantum_cnt <= '0;
                    yield_hold  <= 1'b0;
                end else begin
                    if (quantum_cnt != QW'(QUANTUM)) quantum_cnt <= quantum_cnt + QW'(1);
                    if (quantum_hit) yield_hold <= 1'b1;
                end
            end
        end
    end

    // Return-tag pipeline; reset wipes in-flight tags so no stale returns escape.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= MEM_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[1] <= tag_in;
            for (int i = 2; i <= MEM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_comb begin
        bus.gnt                = own ? owner_oh : '0;
        bus.yield              = (own && (yield_hold || quantum_hit)) ? owner_oh : '0;
        bus.mem_rd             = issue;
        bus.node_index         = own ? bus.node_index_in[owner]   : '0;
        bus.aabb_query_start   = own ? bus.aabb_start_in[owner]   : '0;
        bus.aabb_query_end     = own ? bus.aabb_end_in[owner]     : '0;
        bus.sphere_query_start = own ? bus.sphere_start_in[owner] : '0;
        bus.sphere_query_end   = own ? bus.sphere_end_in[owner]   : '0;
        bus.rdata_valid        = tail_vld ? (NUM_REQ'(1) << tag_pipe[MEM_LAT].owner) : '0;
    end
endmodule

// File: tb/tb_bvh_prim_port_arbiter.sv
module tb_bvh_prim_port_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    bvh_prim_port_arbiter_if #(.NUM_REQ(4), .NODE_W(8), .PRIM_W(8)) bus ();

    bvh_prim_port_arbiter #(
        .NUM_REQ(4), .NODE_W(8), .PRIM_W(8), .MEM_LAT(2), .QUANTUM(64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prio_exp;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.req           = '0;
        bus.release_pulse = '0;
        bus.rd_en         = '0;
        for (int i = 0; i < 4; i++) begin
            bus.node_index_in[i]   = 8'(8'h10 + i);
            bus.aabb_start_in[i]   = 8'(8'h20 + i);
            bus.aabb_end_in[i]     = 8'(8'h30 + i);
            bus.sphere_start_in[i] = 8'(8'h40 + i);
            bus.sphere_end_in[i]   = 8'(8'h50 + i);
        end
        tick; tick;
        chk("rst_gnt",   bus.gnt,         4'b0000);
        chk("rst_yield", bus.yield,       4'b0000);
        chk("rst_memrd", bus.mem_rd,      1'b0);
        chk("rst_rdv",   bus.rdata_valid, 4'b0000);
        chk("rst_node",  bus.node_index,  8'h00);
        reset = 1'b0;
        tick;

        // Round-robin from ptr 0, 1-cycle grant latency
        bus.req = 4'b0101;
        tick;
        chk("grant_rr0",    bus.gnt,                4'b0001);
        chk("mux_node",     bus.node_index,         8'h10);
        chk("mux_aabb_s",   bus.aabb_query_start,   8'h20);
        chk("mux_aabb_e",   bus.aabb_query_end,     8'h30);
        chk("mux_sph_s",    bus.sphere_query_start, 8'h40);
        chk("mux_sph_e",    bus.sphere_query_end,   8'h50);

        // Non-owner release / rd_en ignored
        bus.release_pulse = 4'b1000;
        bus.rd_en         = 4'b1000;
        #1;
        chk("nonowner_memrd", bus.mem_rd, 1'b0);
        tick;
        bus.release_pulse = '0;
        bus.rd_en         = '0;
        chk("nonowner_gnt", bus.gnt, 4'b0001);

        // Owner drops req without release: grant kept
        bus.req = 4'b0100;
        tick;
        chk("req_drop_keep", bus.gnt, 4'b0001);

        bus.release_pulse = 4'b0001;
        tick;
        bus.release_pulse = '0;
        chk("release_gnt_off", bus.gnt, 4'b0000);
        tick;
        chk("next_grant", bus.gnt,        4'b0100);
        chk("next_node",  bus.node_index, 8'h12);

        // Owner 2: three reads, release on the third, then drain
        bus.rd_en = 4'b0100;
        #1;
        chk("issue0_memrd", bus.mem_rd, 1'b1);
        tick;
        chk("rdv_c1", bus.rdata_valid, 4'b0000);
        tick;
        chk("rdv_c2", bus.rdata_valid, 4'b0100);
        bus.release_pulse = 4'b0100;
        #1;
        chk("issue2_memrd", bus.mem_rd, 1'b1);
        tick;
        bus.rd_en         = '0;
        bus.release_pulse = '0;
        bus.req           = 4'b1000;
        chk("drain_c3_gnt",   bus.gnt,         4'b0000);
        chk("drain_c3_rdv",   bus.rdata_valid, 4'b0100);
        chk("drain_c3_memrd", bus.mem_rd,      1'b0);
        tick;
        chk("drain_c4_gnt", bus.gnt,         4'b0000);
        chk("drain_c4_rdv", bus.rdata_valid, 4'b0100);
        tick;
        chk("drain_c5_gnt", bus.gnt,         4'b0000);
        chk("drain_c5_rdv", bus.rdata_valid, 4'b0000);
        tick;
        chk("idle_c6_gnt", bus.gnt, 4'b0000);
        tick;
        chk("post_drain_gnt", bus.gnt, 4'b1000);

        // Release owner 3: rr_ptr wraps to 0, so req 1010 picks unit 1
        bus.release_pulse = 4'b1000;
        bus.req           = '0;
        tick;
        bus.release_pulse = '0;
        chk("wrap_idle_gnt", bus.gnt, 4'b0000);
        bus.req = 4'b1010;
        tick;
        chk("wrap_pick", bus.gnt, 4'b0010);

        // Quantum: yield on the 64th owned cycle, sticky until release
        repeat (62) tick;
        chk("yield_c63", bus.yield, 4'b0000);
        tick;
        chk("yield_c64", bus.yield, 4'b0010);
        tick;
        bus.req = 4'b0010;
        #1;
        chk("yield_sticky_c65", bus.yield, 4'b0010);
        tick;
        chk("yield_sticky_c66", bus.yield, 4'b0010);
        bus.req           = 4'b1010;
        bus.release_pulse = 4'b0010;
        tick;
        bus.release_pulse = '0;
        chk("yield_rel_yield", bus.yield, 4'b0000);
        chk("yield_rel_gnt",   bus.gnt,   4'b0000);
        tick;
        chk("yield_handoff", bus.gnt, 4'b1000);

        // Reset with two reads in flight
        bus.rd_en = 4'b1000;
        tick;
        tick;
        bus.rd_en = '0;
        bus.req   = '0;
        chk("pre_reset_rdv", bus.rdata_valid, 4'b1000);
        reset = 1'b1;
        #1;
        chk("async_rst_gnt",   bus.gnt,         4'b0000);
        chk("async_rst_rdv",   bus.rdata_valid, 4'b0000);
        chk("async_rst_yield", bus.yield,       4'b0000);
        chk("async_rst_memrd", bus.mem_rd,      1'b0);
        tick; tick;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("post_rst_rdv", bus.rdata_valid, 4'b0000);
        end

        // Move rr_ptr to 2, then req 1101
        bus.req = 4'b0010;
        tick;
        chk("prio_setup_gnt", bus.gnt, 4'b0010);
        bus.release_pulse = 4'b0010;
        bus.req           = '0;
        tick;
        bus.release_pulse = '0;
        bus.req           = 4'b1101;
        tick;
`ifdef BVH_ARB_PRIORITY_EN
        prio_exp = 4'b0001;
`else
        prio_exp = 4'b0100;
`endif
        chk("prio_pick", bus.gnt, prio_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bvh_prim_port_arbiter.md
Name: bvh_prim_port_arbiter

Overview:
- Shares the single BVH node-fetch port and the primitive query ports (AABB and sphere) between NUM_REQ traversal units, for example the shadow any-hit unit and the closest-hit unit.
- Grants one owner at a time with round-robin fairness; the owner holds the grant for a whole traversal.
- Tags memory read returns with the owner index so that return data is routed only to the unit that issued the read.
- Sits between the ray-core stages and the BVH/primitive memories.

Parameters:
- NUM_REQ, 4, number of requesting units (2..8).
- NODE_W, 8, BVH node index width.
- PRIM_W, 8, primitive index width.
- MEM_LAT, 2, read latency in cycles from address out to data valid (1..4).
- QUANTUM, 64, owner cycles before yield is raised.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- req  in  NUM_REQ  per-unit request; level-held until grant.
- release  in  NUM_REQ  per-unit one-cycle pulse; only the owner's bit is honoured.
- rd_en  in  NUM_REQ  per-unit read issue; only the owner's bit is honoured.
- node_index_in  in  NUM_REQ*NODE_W  per-unit node address.
- aabb_start_in / aabb_end_in  in  NUM_REQ*PRIM_W each  per-unit AABB range.
- sphere_start_in / sphere_end_in  in  NUM_REQ*PRIM_W each  per-unit sphere range.
- gnt  out  NUM_REQ  one-hot grant; all zero when idle.
- yield  out  NUM_REQ  owner's bit set when quantum expired and others are waiting.
- node_index  out  NODE_W  muxed node address to memory.
- aabb_query_start / aabb_query_end / sphere_query_start / sphere_query_end  out  PRIM_W each  muxed query to memory.
- mem_rd  out  1  read strobe to memory.
- rdata_valid  out  NUM_REQ  one-hot marking whose read data is on the shared memory outputs this cycle.

Behaviour:
- Reset (asynchronous, active-high): gnt=0, yield=0, mem_rd=0, rdata_valid=0, all address outputs 0, state ARB_Idle, rr_ptr=0, inflight=0, quantum_cnt=0.
- States:
  - ARB_Idle: on any req, pick the first set bit scanning from rr_ptr upward with wrap. Next cycle is ARB_Own with gnt set for that bit; grant latency is 1 cycle from req.
  - ARB_Own:
    - Address outputs = owner's inputs, combinationally muxed by the registered owner.
    - mem_rd = rd_en[owner] & gnt; non-owner rd_en is ignored.
    - quantum_cnt increments, saturating at QUANTUM.
    - yield[owner]=1 when quantum_cnt==QUANTUM and any other req is pending; it stays asserted until release.
    - On release[owner]: gnt drops the next cycle, and rr_ptr = owner+1 mod NUM_REQ.
    - Transition to ARB_Drain if inflight!=0, otherwise ARB_Idle.
  - ARB_Drain: no grant and no mem_rd. Return to ARB_Idle when inflight==0. A new owner is never granted while the previous owner's reads are outstanding.
- Return tagging:
  - A MEM_LAT-deep shift pipeline carries {valid, owner} for each mem_rd.
  - rdata_valid = onehot(tag) at the tail, exactly MEM_LAT cycles after mem_rd.
- inflight counter:
  - +1 on mem_rd, -1 on tail valid; simultaneous increment and decrement leaves it unchanged.
  - Width clog2(MEM_LAT+1); it can never overflow because at most one issue happens per cycle.
- Boundary cases:
  - release on the same cycle as rd_en: that read is issued and tagged, and drain covers it.
  - release from a non-owner: ignored.
  - Owner's req dropping without release: the grant is kept; release is the only exit.
  - Reset mid-traversal: pipeline tags are cleared, so no rdata_valid is emitted for reads in flight.
  - Single requester: re-granted immediately after Idle, giving a 1-cycle bubble between grants.
  - rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: BVH_ARB_PRIORITY_EN.
- Defined: at the ARB_Idle decision, req[0] (the primary-ray unit) wins over all others regardless of rr_ptr. Round-robin applies among the remaining requesters. yield is still raised to unit 0 after its quantum.
- Undefined: pure round-robin for all units, unit 0 included.

Decomposition:
- Shared package holds:
  - ArbState enum (ARB_Idle, ARB_Own, ARB_Drain).
  - ReturnTag struct {valid, owner}.
  - Width constants aliased to BVH_NODE_INDEX_WIDTH and BVH_PRIMITIVE_INDEX_WIDTH.
- One sub-module: rr_pick (combinational rotate-priority encoder, NUM_REQ-wide, rr_ptr input, outputs index plus found flag), reused by other arbiters.

Test Plan:
- req=0101, rr_ptr=0 -> gnt=0001 after 1 cycle; release[0] -> gnt=0000, then 0100 two cycles later.
- Owner 2 issues rd_en on 3 consecutive cycles with MEM_LAT=2 -> rdata_valid=0100 on cycles +2, +3, +4; release on the 3rd issue -> ARB_Drain until inflight=0, with no gnt in between.
- Owner 1 holds 64 cycles while req[3]=1 -> yield=0010 on cycle 64; it stays until release; next gnt=1000.
- Non-owner release[3] pulse and rd_en[3] while owner=0 -> no state change, mem_rd=0.
- Reset asserted with 2 reads in flight -> gnt, rdata_valid, and yield are 0 immediately (asynchronous), and no stale rdata_valid appears after reset deasserts.
- BVH_ARB_PRIORITY_EN defined, rr_ptr=2, req=1101 -> gnt=0001. Undefined, same stimulus -> gnt=0100.
